abs_share_ctrl: RTL and testbench

- Time-multiplexes one shared registered absolute-value unit among NUM_REQ requesters using round-robin arbitration.
- The shared unit has an 11-bit signed input, a 10-bit magnitude output, 1-cycle latency, and no stall.
- The controller registers the selected operand, tracks each in-flight operation's requester ID through the unit's fixed latency, and collects results in an output FIFO.
- The FIFO provides a valid/ready result interface with full backpressure.
- The block sits between the sample sources and the downstream magnitude consumer.

---
 rtl/abs_share_ctrl_if.sv | 31 +++
 rtl/abs_share_ctrl.sv | 118 +++++++++++
 tb/tb_abs_share_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/abs_share_ctrl_if.sv
// Bundle between abs_share_ctrl and its environment.
//   req_valid/req_data/req_ready : requester side, one-hot grant handshake
//   abs_in/abs_out               : link to the shared registered abs unit
//   res_valid/res_id/res_data/res_ready : result stream with backpressure
// Modports: master = controller view, slave = environment view.
interface abs_share_ctrl_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 11
) ();
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic signed [DATA_WIDTH-1:0]  abs_in;
  logic [DATA_WIDTH-2:0]         abs_out;
  logic                          res_valid;
  logic [ID_W-1:0]               res_id;
  logic [DATA_WIDTH-2:0]         res_data;
  logic                          res_ready;

  modport master (
    input  req_valid, req_data, abs_out, res_ready,
    output req_ready, abs_in, res_valid, res_id, res_data
  );

  modport slave (
    output req_valid, req_data, abs_out, res_ready,
    input  req_ready, abs_in, res_valid, res_id, res_data
  );
endinterface

// File: rtl/abs_share_ctrl.sv
// Round-robin time-multiplexing controller for one shared registered
// absolute-value unit (1-cycle latency, no stall).
//   clk : clock, posedge
//   rst : synchronous active-high reset (also resets the shared unit)
//   bus : abs_share_ctrl_if.master -- requester handshake, shared-unit
//         operand/result link, and the FIFO-backed result stream.
// Issue is gated by a credit check so every operation in flight already owns
// a FIFO slot; the FIFO therefore can never overflow.
module abs_share_ctrl #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  abs_share_ctrl_if.master  bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int RES_W = DATA_WIDTH - 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = PTR_W + 2;

  logic [ID_W-1:0]              last;
  logic [NUM_REQ-1:0]           grant;
  logic [ID_W-1:0]              grant_id;
  logic                         found;
  logic [ID_W:0]                scan_sum;
  logic [ID_W-1:0]              scan_idx;
  logic signed [DATA_WIDTH-1:0] sel_data;
  logic                         transfer;
  logic                         issue_ok;
  logic [OCC_W-1:0]             occ;

  logic signed [DATA_WIDTH-1:0] abs_in_p1;
  logic                         vld_p1, vld_p2;
  logic [ID_W-1:0]              id_p1, id_p2;

  logic [ID_W+RES_W-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [CNT_W-1:0]             count;
  logic [ID_W+RES_W-1:0]        head;
  logic                         push, pop;

  assign push = vld_p2;
  assign pop  = bus.res_valid && bus.res_ready;

  // Occupancy counts every op that will land in the FIFO, minus this cycle's pop.
  assign occ      = OCC_W'(vld_p1) + OCC_W'(vld_p2) + OCC_W'(count) - OCC_W'(pop);
  assign issue_ok = !rst && (occ < OCC_W'(FIFO_DEPTH));

  // Round-robin scan starting just after the last granted index.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    sel_data = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_sum = {1'b0, last} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NUM_REQ))
        scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
      scan_idx = scan_sum[ID_W-1:0];
      if (!found && issue_ok && bus.req_valid[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_id        = scan_idx;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i])
        sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign transfer      = found;
  assign bus.req_ready = grant;
  assign bus.abs_in    = abs_in_p1;

  // Control state: arbitration pointer, stage valids, FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= ID_W'(NUM_REQ - 1);
      abs_in_p1 <= '0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      // Stage p1: operand register feeding the shared unit.
      if (transfer) begin
        last      <= grant_id;
        abs_in_p1 <= sel_data;
      end
      vld_p1 <= transfer;
      // Stage p2: shared unit output valid, written to FIFO next edge.
      vld_p2 <= vld_p1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Data path: requester tags and FIFO storage, qualified by the valids above.
  always_ff @(posedge clk) begin
    if (transfer) id_p1 <= grant_id;
    id_p2 <= id_p1;
    if (push) mem[wr_ptr] <= {id_p2, bus.abs_out};
  end

  // Result stream: head forced to zero when empty so reset state reads clean.
  assign head          = mem[rd_ptr];
  assign bus.res_valid = (count != '0);
  assign bus.res_id    = bus.res_valid ? head[ID_W+RES_W-1:RES_W] : '0;
  assign bus.res_data  = bus.res_valid ? head[RES_W-1:0] : '0;
endmodule

// File: tb/tb_abs_share_ctrl.sv
// Directed self-checking bench for abs_share_ctrl with a behavioural model
// of the shared registered absolute-value unit.
module tb_abs_share_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  abs_share_ctrl_if #(.NUM_REQ(4), .DATA_WIDTH(11)) ifc ();

  abs_share_ctrl #(.NUM_REQ(4), .DATA_WIDTH(11), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // Shared unit: 1-cycle registered magnitude, truncated to 10 bits.
  logic signed [10:0] neg_in;
  assign neg_in = -ifc.abs_in;
  always_ff @(posedge clk) begin
    if (rst) ifc.abs_out <= '0;
    else     ifc.abs_out <= ifc.abs_in[10] ? neg_in[9:0] : ifc.abs_in[9:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [10:0] v);
    ifc.req_data[i*11 +: 11] = v;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    ifc.req_valid = '0;
    ifc.res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [1:0] id, input logic [9:0] d);
    chk({tag, "_valid"}, 32'(ifc.res_valid), 32'd1);
    chk({tag, "_id"},    32'(ifc.res_id),    32'(id));
    chk({tag, "_data"},  32'(ifc.res_data),  32'(d));
  endtask

  initial begin
    ifc.req_valid = '0;
    ifc.req_data  = '0;
    ifc.res_ready = 1'b0;

    // Reset state
    tick();
    tick();
    #1;
    chk("rst_req_ready", 32'(ifc.req_ready), 32'd0);
    chk("rst_abs_in",    {21'b0, ifc.abs_in}, 32'd0);
    chk("rst_res_valid", 32'(ifc.res_valid), 32'd0);
    chk("rst_res_id",    32'(ifc.res_id),    32'd0);
    chk("rst_res_data",  32'(ifc.res_data),  32'd0);
    ifc.req_valid = 4'hF;
    #1;
    chk("rst_no_grant", 32'(ifc.req_ready), 32'd0);
    reset_dut();

    // Single request from requester 2, operand -5
    tick();
    set_data(2, 11'h7FB);
    ifc.req_valid = 4'b0100;
    #1;
    chk("single_grant", 32'(ifc.req_ready), 32'h4);
    tick();
    ifc.req_valid = '0;
    #1;
    chk("single_abs_in", {21'b0, ifc.abs_in}, 32'h7FB);
    chk("single_e0_rv",  32'(ifc.res_valid), 32'd0);
    tick();
    chk("single_e1_rv",  32'(ifc.res_valid), 32'd0);
    tick();
    chk_res("single_e2", 2'd2, 10'd5);
    tick();
    chk_res("single_hold", 2'd2, 10'd5);
    ifc.res_ready = 1'b1;
    tick();
    chk("single_popped", 32'(ifc.res_valid), 32'd0);

    // All four valid, continuous flow
    reset_dut();
    for (int i = 0; i < 4; i++) set_data(i, 11'(-(i + 1)));
    ifc.req_valid = 4'hF;
    ifc.res_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk($sformatf("stream_grant%0d", k), 32'(ifc.req_ready), 32'(1 << (k % 4)));
      if (k >= 3)
        chk_res($sformatf("stream_res%0d", k), 2'((k - 3) % 4), 10'((k - 3) % 4 + 1));
      tick();
    end

    // Backpressure: exactly FIFO_DEPTH transfers, then ordered drain
    reset_dut();
    ifc.req_valid = 4'hF;
    ifc.res_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("bp_grant%0d", k), 32'(ifc.req_ready), (k < 4) ? 32'(1 << k) : 32'd0);
      tick();
    end
    chk_res("bp_full_head", 2'd0, 10'd1);
    ifc.res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("drain_grant%0d", k), 32'(ifc.req_ready), 32'(1 << (k % 4)));
      chk_res($sformatf("drain_res%0d", k), 2'(k % 4), 10'(k % 4 + 1));
      tick();
    end

    // Boundary operands
    reset_dut();
    set_data(0, 11'sd1023);
    set_data(1, 11'sd0);
    set_data(2, -11'sd1);
    set_data(3, 11'h400);
    ifc.res_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      ifc.req_valid = (k < 4) ? 4'hF : 4'h0;
      #1;
      if (k == 3) chk_res("bnd_pos_max", 2'd0, 10'd1023);
      if (k == 4) chk_res("bnd_zero",    2'd1, 10'd0);
      if (k == 5) chk_res("bnd_minus1",  2'd2, 10'd1);
      if (k == 6) chk_res("bnd_neg_min", 2'd3, 10'd0);
      tick();
    end

    // Reset with operations in flight and queued
    reset_dut();
    for (int i = 0; i < 4; i++) set_data(i, 11'(-(i + 1)));
    ifc.req_valid = 4'hF;
    ifc.res_ready = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_comb_grant", 32'(ifc.req_ready), 32'd0);
    tick();
    chk("mid_rst_res_valid", 32'(ifc.res_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(ifc.req_ready), 32'd0);
    chk("mid_rst_abs_in",    {21'b0, ifc.abs_in}, 32'd0);
    tick();
    rst = 1'b0;
    set_data(0, 11'sd7);
    ifc.req_valid = 4'b0011;
    ifc.res_ready = 1'b1;
    #1;
    chk("post_rst_prio0", 32'(ifc.req_ready), 32'h1);
    tick();
    chk("post_rst_next1", 32'(ifc.req_ready), 32'h2);
    tick();
    ifc.req_valid = '0;
    #1;
    chk("post_rst_no_stale_a", 32'(ifc.res_valid), 32'd0);
    tick();
    chk_res("post_rst_first", 2'd0, 10'd7);
    tick();
    chk_res("post_rst_second", 2'd1, 10'd2);
    tick();
    chk("post_rst_empty", 32'(ifc.res_valid), 32'd0);

    // Lone requester 3, then requester 1 joins
    reset_dut();
    set_data(1, 11'sd10);
    set_data(3, 11'sd30);
    ifc.res_ready = 1'b1;
    ifc.req_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("lone3_grant%0d", k), 32'(ifc.req_ready), 32'h8);
      tick();
    end
    ifc.req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("alt_grant%0d", k), 32'(ifc.req_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
